// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//
// Holds the predictions issued by the branch history table, in program order,
// until each branch resolves. A resolution pops the oldest entry. One cycle
// later a training update (pc, actual outcome) goes back to the BHT, together
// with a flag saying whether the prediction was wrong. Saturating counters
// track how many branches resolved and how many were predicted correctly.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   flush               synchronous discard of every queued entry
//   pred_valid/pc/taken incoming prediction; pred_ready = queue not full
//   res_valid/taken     resolution of the oldest branch; res_ready = not empty
//   upd_valid/pc/taken  registered one-cycle BHT training strobe
//   mispredict          qualifies upd_valid: prediction differed from outcome
//   occupancy           number of entries currently held
//   total_cnt           resolved branches (saturating)
//   correct_cnt         correctly predicted branches (saturating)
//   underflow_err       sticky: a resolution arrived while the queue was empty

module branch_resolve_queue #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_ready,
    output logic                     upd_valid,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         correct_cnt,
    output logic                     underflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [PC_W-1:0]  pc_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [PC_W-1:0]  head_pc;
    logic             head_taken;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_idx == wr_idx) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

    // Handshakes depend on registered pointers only, so a push is refused
    // while full even if a pop frees a slot in the same cycle.
    assign pred_ready = !full;
    assign res_ready  = !empty;
    assign occupancy  = wr_ptr - rd_ptr;

    // Flush overrides any same-cycle push or pop.
    assign do_push = pred_valid && !full  && !flush;
    assign do_pop  = res_valid  && !empty && !flush;

    assign head_pc    = pc_mem[rd_idx];
    assign head_taken = taken_mem[rd_idx];

    // Entry storage has no reset; only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_idx]    <= pred_pc;
            taken_mem[wr_idx] <= pred_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // The training payload is only rewritten on a pop, so it holds its last
    // value whenever upd_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid  <= 1'b0;
            upd_pc     <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid <= do_pop;
            if (do_pop) begin
                upd_pc     <= head_pc;
                upd_taken  <= res_taken;
                mispredict <= head_taken ^ res_taken;
            end
        end
    end

    // Accuracy counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
        end else if (do_pop) begin
            if (total_cnt != '1)
                total_cnt <= total_cnt + CNT_W'(1);
            if ((head_taken == res_taken) && (correct_cnt != '1))
                correct_cnt <= correct_cnt + CNT_W'(1);
        end
    end

    // A resolution with nothing queued is a protocol error on the resolving
    // side; it is flagged even during a flush and is cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            underflow_err <= 1'b0;
        else if (res_valid && empty)
            underflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences (fill/overflow,
// steady-state streaming across pointer wrap, underflow, flush, async reset).

module tb_branch_resolve_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        pred_valid;
    logic [8:0]  pred_pc;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        res_ready;
    logic        upd_valid;
    logic [8:0]  upd_pc;
    logic        upd_taken;
    logic        mispredict;
    logic [3:0]  occupancy;
    logic [31:0] total_cnt;
    logic [31:0] correct_cnt;
    logic        underflow_err;

    int errors = 0;
    int checks = 0;

    branch_resolve_queue #(.PC_W(9), .DEPTH(8), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .pred_valid   (pred_valid),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .pred_ready   (pred_ready),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_ready    (res_ready),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .mispredict   (mispredict),
        .occupancy    (occupancy),
        .total_cnt    (total_cnt),
        .correct_cnt  (correct_cnt),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [8:0] ppc;
        logic       pt;
        logic       rv;
        logic       rt;
        logic       fl;
        logic       e_uv;
        logic [8:0] e_upc;
        logic       e_ut;
        logic       e_mis;
        int         e_occ;
        int         e_total;
        int         e_correct;
    } vec_t;

    typedef struct {
        logic [8:0] pc;
        logic       taken;
    } entry_t;

    vec_t   vecs[10];
    entry_t model_q[$];

    function automatic vec_t mk(logic pv, logic [8:0] ppc, logic pt, logic rv,
                                logic rt, logic fl, logic e_uv, logic [8:0] e_upc,
                                logic e_ut, logic e_mis, int e_occ, int e_total,
                                int e_correct);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pt = pt; v.rv = rv; v.rt = rt; v.fl = fl;
        v.e_uv = e_uv; v.e_upc = e_upc; v.e_ut = e_ut; v.e_mis = e_mis;
        v.e_occ = e_occ; v.e_total = e_total; v.e_correct = e_correct;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then return 1 time unit
    // after the following rising edge so outputs can be sampled.
    task automatic applyStimulus(input logic pv, input logic [8:0] ppc, input logic pt,
                                 input logic rv, input logic rt, input logic fl);
        @(negedge clk);
        pred_valid = pv;
        pred_pc    = ppc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
        pred_pc = '0; pred_taken = 1'b0; res_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int tot;
        int cor;
        entry_t exp_e;

        reset = 1'b0;
        flush = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0;

        //                 pv  ppc     pt  rv  rt  fl   uv  upc     ut  mis occ tot cor
        vecs[0] = mk(1, 9'h010, 1, 0, 0, 0,  0, 9'h000, 0, 0, 1, 0, 0);
        vecs[1] = mk(1, 9'h020, 0, 0, 0, 0,  0, 9'h000, 0, 0, 2, 0, 0);
        vecs[2] = mk(1, 9'h030, 1, 0, 0, 0,  0, 9'h000, 0, 0, 3, 0, 0);
        vecs[3] = mk(0, 9'h000, 0, 1, 1, 0,  1, 9'h010, 1, 0, 2, 1, 1);
        vecs[4] = mk(0, 9'h000, 0, 1, 1, 0,  1, 9'h020, 1, 1, 1, 2, 1);
        vecs[5] = mk(0, 9'h000, 0, 1, 1, 0,  1, 9'h030, 1, 0, 0, 3, 2);
        vecs[6] = mk(0, 9'h000, 0, 0, 0, 0,  0, 9'h030, 1, 0, 0, 3, 2);
        vecs[7] = mk(1, 9'h0AB, 0, 0, 0, 0,  0, 9'h030, 1, 0, 1, 3, 2);
        vecs[8] = mk(1, 9'h0CD, 1, 1, 0, 0,  1, 9'h0AB, 0, 0, 1, 4, 3);
        vecs[9] = mk(0, 9'h000, 0, 1, 0, 0,  1, 9'h0CD, 0, 1, 0, 5, 3);

        doReset();

        // Reset state
        checkOutput("rst upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("rst upd_pc", 32'(upd_pc), 32'd0);
        checkOutput("rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst pred_ready", 32'(pred_ready), 32'd1);
        checkOutput("rst res_ready", 32'(res_ready), 32'd0);
        checkOutput("rst total_cnt", total_cnt, 32'd0);
        checkOutput("rst underflow_err", 32'(underflow_err), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].rv, vecs[i].rt, vecs[i].fl);
            checkOutput($sformatf("vec%0d upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
            checkOutput($sformatf("vec%0d upd_pc", i), 32'(upd_pc), 32'(vecs[i].e_upc));
            checkOutput($sformatf("vec%0d upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
            checkOutput($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
            checkOutput($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            checkOutput($sformatf("vec%0d pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_occ != 8));
            checkOutput($sformatf("vec%0d res_ready", i), 32'(res_ready), 32'(vecs[i].e_occ != 0));
            checkOutput($sformatf("vec%0d total_cnt", i), total_cnt, 32'(vecs[i].e_total));
            checkOutput($sformatf("vec%0d correct_cnt", i), correct_cnt, 32'(vecs[i].e_correct));
        end

        // Fill to capacity, overflow attempts, push+pop while full, drain
        doReset();
        model_q.delete();
        tot = 0;
        cor = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 9'(9'h100 + i), i[0], 1'b0, 1'b0, 1'b0);
            exp_e.pc = 9'(9'h100 + i);
            exp_e.taken = i[0];
            model_q.push_back(exp_e);
        end
        checkOutput("full occupancy", 32'(occupancy), 32'd8);
        checkOutput("full pred_ready", 32'(pred_ready), 32'd0);
        checkOutput("full res_ready", 32'(res_ready), 32'd1);

        applyStimulus(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("overflow occupancy", 32'(occupancy), 32'd8);

        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_e = model_q.pop_front();
        tot++;
        if (exp_e.taken) cor++;
        checkOutput("pop-after-full upd_valid", 32'(upd_valid), 32'd1);
        checkOutput("pop-after-full upd_pc", 32'(upd_pc), 32'h100);
        checkOutput("pop-after-full mispredict", 32'(mispredict), 32'd1);
        checkOutput("pop-after-full occupancy", 32'(occupancy), 32'd7);
        checkOutput("pop-after-full pred_ready", 32'(pred_ready), 32'd1);

        applyStimulus(1'b1, 9'h1AA, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_e.pc = 9'h1AA;
        exp_e.taken = 1'b1;
        model_q.push_back(exp_e);
        checkOutput("refill occupancy", 32'(occupancy), 32'd8);
        checkOutput("refill upd_valid", 32'(upd_valid), 32'd0);

        // Push while full is refused even though a pop happens this cycle
        applyStimulus(1'b1, 9'h1BB, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_e = model_q.pop_front();
        tot++;
        if (exp_e.taken) cor++;
        checkOutput("full push+pop upd_pc", 32'(upd_pc), 32'h101);
        checkOutput("full push+pop occupancy", 32'(occupancy), 32'd7);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
            exp_e = model_q.pop_front();
            tot++;
            if (exp_e.taken) cor++;
            checkOutput($sformatf("drain%0d upd_pc", i), 32'(upd_pc), 32'(exp_e.pc));
            checkOutput($sformatf("drain%0d mispredict", i), 32'(mispredict), 32'(!exp_e.taken));
            checkOutput($sformatf("drain%0d occupancy", i), 32'(occupancy), 32'(6 - i));
        end
        checkOutput("drain total_cnt", total_cnt, 32'(tot));
        checkOutput("drain correct_cnt", correct_cnt, 32'(cor));
        checkOutput("drain res_ready", 32'(res_ready), 32'd0);

        // Half-full streaming: push and pop every cycle across pointer wrap
        doReset();
        model_q.delete();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 9'(9'h040 + k), k[0], 1'b0, 1'b0, 1'b0);
            exp_e.pc = 9'(9'h040 + k);
            exp_e.taken = k[0];
            model_q.push_back(exp_e);
        end
        for (int c = 0; c < 20; c++) begin
            entry_t head;
            head = model_q.pop_front();
            exp_e.pc = 9'(9'h044 + c);
            exp_e.taken = c[0];
            model_q.push_back(exp_e);
            applyStimulus(1'b1, exp_e.pc, exp_e.taken, 1'b1, c[1], 1'b0);
            checkOutput($sformatf("stream%0d upd_valid", c), 32'(upd_valid), 32'd1);
            checkOutput($sformatf("stream%0d upd_pc", c), 32'(upd_pc), 32'(head.pc));
            checkOutput($sformatf("stream%0d upd_taken", c), 32'(upd_taken), 32'(c[1]));
            checkOutput($sformatf("stream%0d mispredict", c), 32'(mispredict), 32'(head.taken ^ c[1]));
            checkOutput($sformatf("stream%0d occupancy", c), 32'(occupancy), 32'd4);
        end
        checkOutput("stream total_cnt", total_cnt, 32'd20);

        // Resolution while empty
        doReset();
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("underflow upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("underflow total_cnt", total_cnt, 32'd0);
        checkOutput("underflow occupancy", 32'(occupancy), 32'd0);
        checkOutput("underflow flag", 32'(underflow_err), 32'd1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("underflow after flush", 32'(underflow_err), 32'd1);

        // Flush beats a same-cycle push and pop; counters survive
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 9'(9'h080 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("preflush occupancy", 32'(occupancy), 32'd4);
        checkOutput("preflush total_cnt", total_cnt, 32'd1);
        applyStimulus(1'b1, 9'h0EE, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("flush occupancy", 32'(occupancy), 32'd0);
        checkOutput("flush upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("flush total_cnt", total_cnt, 32'd1);
        checkOutput("flush correct_cnt", correct_cnt, 32'd1);
        checkOutput("flush res_ready", 32'(res_ready), 32'd0);
        checkOutput("flush underflow kept", 32'(underflow_err), 32'd1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("postflush occupancy", 32'(occupancy), 32'd0);

        // Async reset mid-stream, checked without any clock edge
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 9'(9'h0C0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("prereset upd_valid", 32'(upd_valid), 32'd1);
        checkOutput("prereset upd_pc", 32'(upd_pc), 32'h0C0);
        res_valid = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("async upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("async upd_pc", 32'(upd_pc), 32'd0);
        checkOutput("async upd_taken", 32'(upd_taken), 32'd0);
        checkOutput("async mispredict", 32'(mispredict), 32'd0);
        checkOutput("async occupancy", 32'(occupancy), 32'd0);
        checkOutput("async total_cnt", total_cnt, 32'd0);
        checkOutput("async correct_cnt", correct_cnt, 32'd0);
        checkOutput("async underflow_err", 32'(underflow_err), 32'd0);
        checkOutput("async res_ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postreset occupancy", 32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
